// File: rtl/imply_serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial IMPLY adder controller.
interface imply_serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/imply_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer sharing one IMPLY full-adder cell across all bits.
// Each bit's cell inputs are held SETTLE cycles; Sum/Cout are sampled only on the last one.
module imply_serial_adder_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    imply_serial_adder_ctrl_if.slave bus,
    output logic fa_a,
    output logic fa_b,
    output logic fa_cin,
    input  logic fa_sum,
    input  logic fa_cout
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    // state | meaning
    // IDLE  | waiting for start, cell inputs parked at 0
    // DRIVE | bit idx presented to the cell, cnt counts down the settle time
    // DONE  | one-cycle result strobe, cell inputs back at 0
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-2:0] shadow;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_inc;
    logic [CW-1:0]    cnt;
    logic             bit_end;

    assign idx_inc = idx + 1'b1;
    assign bit_end = (state == S_DRIVE) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_DRIVE;
            S_DRIVE: if (bit_end && (idx == IDX_LAST)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != S_IDLE);
        bus.done = (state == S_DONE);
    end

    // Cell inputs are registered so they change only on bit boundaries, never mid-settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa     <= '0;
            opb     <= '0;
            shadow  <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            fa_a    <= 1'b0;
            fa_b    <= 1'b0;
            fa_cin  <= 1'b0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
            bus.ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.op ? ~bus.b : bus.b;
                        carry  <= bus.op | bus.cin;
                        idx    <= '0;
                        cnt    <= CNT_INIT;
                        fa_a   <= bus.a[0];
                        fa_b   <= bus.b[0] ^ bus.op;
                        fa_cin <= bus.op | bus.cin;
                    end
                end
                S_DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        carry <= fa_cout;
                        if (idx == IDX_LAST) begin
                            bus.sum  <= {fa_sum, shadow};
                            bus.cout <= fa_cout;
                            bus.ovf  <= carry ^ fa_cout;
                            fa_a     <= 1'b0;
                            fa_b     <= 1'b0;
                            fa_cin   <= 1'b0;
                        end else begin
                            shadow[idx] <= fa_sum;
                            idx         <= idx_inc;
                            cnt         <= CNT_INIT;
                            fa_a        <= opa[idx_inc];
                            fa_b        <= opb[idx_inc];
                            fa_cin      <= fa_cout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imply_serial_adder_ctrl.sv
// Bench for imply_serial_adder_ctrl: three instances (SETTLE 2/1/4) each with a glitching cell model.
module tb_imply_serial_adder_ctrl;
    localparam int W = 8;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        start_v, op_v, cin_v;
    logic [N-1:0][W-1:0] a_v, b_v, sum_v;
    logic [N-1:0]        busy_v, done_v, cout_v, ovf_v, fa_a_v, fa_b_v, fa_cin_v;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        imply_serial_adder_ctrl_if #(.WIDTH(W)) bus ();
        logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout, glitch;
        logic [2:0] prev_in;

        assign bus.start    = start_v[g];
        assign bus.op       = op_v[g];
        assign bus.a        = a_v[g];
        assign bus.b        = b_v[g];
        assign bus.cin      = cin_v[g];
        assign busy_v[g]    = bus.busy;
        assign done_v[g]    = bus.done;
        assign sum_v[g]     = bus.sum;
        assign cout_v[g]    = bus.cout;
        assign ovf_v[g]     = bus.ovf;
        assign fa_a_v[g]    = fa_a;
        assign fa_b_v[g]    = fa_b;
        assign fa_cin_v[g]  = fa_cin;

        // Cell outputs are wrong for the first cycle after any input change.
        always @(posedge clk) prev_in <= {fa_a, fa_b, fa_cin};
        assign glitch  = (S > 1) && (prev_in != {fa_a, fa_b, fa_cin});
        assign fa_sum  = (fa_a ^ fa_b ^ fa_cin) ^ glitch;
        assign fa_cout = ((fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b))) ^ glitch;

        imply_serial_adder_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
            .clk(clk), .rst(rst), .bus(bus),
            .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
            .fa_sum(fa_sum), .fa_cout(fa_cout)
        );
    end

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] outs(input int k);
        return {busy_v[k], done_v[k], cout_v[k], ovf_v[k],
                fa_a_v[k], fa_b_v[k], fa_cin_v[k], sum_v[k]};
    endfunction

    // One operation on instance k; optional stray start at cycle inject_at, reset at cycle rst_at.
    task automatic do_op(input int k, input logic opv, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic cinv,
                         input int inject_at, input int rst_at, output logic [2:0] fa_first);
        int           s;
        int           lat;
        int           n;
        int           j;
        int           busy_cnt;
        int           drv_err;
        int           hold_err;
        int           done_seen;
        logic [W:0]   full;
        logic [W:0]   m;
        logic [W:0]   part;
        logic [W-1:0] bb;
        logic [W-1:0] old_sum;
        logic         old_cout, old_ovf, c0;
        exp_t         e;
        exp_t         got;
        s = settle_of(k);
        lat = 1 + W * s;
        n = 0; busy_cnt = 0; drv_err = 0; hold_err = 0; done_seen = 0;
        fa_first = 3'b000;
        bb = opv ? ~bv : bv;
        c0 = opv | cinv;
        full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, c0};
        e.sum = full[W-1:0];
        e.cout = full[W];
        e.ovf = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
        old_sum = sum_v[k]; old_cout = cout_v[k]; old_ovf = ovf_v[k];

        @(negedge clk);
        a_v[k] = av; b_v[k] = bv; op_v[k] = opv; cin_v[k] = cinv; start_v[k] = 1'b1;
        if (rst_at == 0) sb.push_back(e);

        while (n < lat + 10) begin
            @(negedge clk);
            n++;
            if (n == 1) start_v[k] = 1'b0;
            if (inject_at > 0 && n == inject_at) begin
                start_v[k] = 1'b1; a_v[k] = ~av; b_v[k] = av; op_v[k] = ~opv;
            end
            if (inject_at > 0 && n == inject_at + 1) start_v[k] = 1'b0;
            if (rst_at > 0 && n == rst_at + 1) begin
                rst = 1'b0;
                check("rst_clear", 32'(outs(k)), 32'h0);
            end
            if (rst_at > 0 && n > rst_at) begin
                if (done_v[k]) done_seen++;
                if (n >= lat + 3) break;
            end else begin
                if (busy_v[k]) busy_cnt++;
                if (n == 1) fa_first = {fa_a_v[k], fa_b_v[k], fa_cin_v[k]};
                if (n < lat) begin
                    j = (n - 1) / s;
                    m = (W+1)'((1 << j) - 1);
                    part = ({1'b0, av} & m) + ({1'b0, bb} & m) + {{W{1'b0}}, c0};
                    if ({fa_a_v[k], fa_b_v[k], fa_cin_v[k]} !== {av[j], bb[j], part[j]})
                        drv_err++;
                    if ({sum_v[k], cout_v[k], ovf_v[k]} !== {old_sum, old_cout, old_ovf})
                        hold_err++;
                end
                if (done_v[k]) break;
            end
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
        end

        if (rst_at > 0) begin
            check("rst_no_done", 32'(done_seen), 32'd0);
        end else begin
            check("latency", 32'(n), 32'(lat));
            check("busy_cycles", 32'(busy_cnt), 32'(lat));
            check("cell_drive", 32'(drv_err), 32'd0);
            check("held_result", 32'(hold_err), 32'd0);
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check("sum", 32'(sum_v[k]), 32'(got.sum));
                check("cout", 32'(cout_v[k]), 32'(got.cout));
                check("ovf", 32'(ovf_v[k]), 32'(got.ovf));
            end
            @(negedge clk);
            check("done_pulse", 32'({done_v[k], busy_v[k]}), 32'd0);
        end
    endtask

    logic [2:0] ff;

    initial begin
        rst = 1'b1;
        start_v = '0; op_v = '0; cin_v = '0; a_v = '0; b_v = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) check("reset_state", 32'(outs(k)), 32'h0);
        rst = 1'b0;

        do_op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, 0, 0, ff);
        check("add_5a_3c_sum", 32'(sum_v[0]), 32'h96);

        do_op(0, 1'b1, 8'h10, 8'h20, 1'b0, 0, 0, ff);
        check("sub_bit0_fa", 32'(ff), 32'b011);
        check("sub_sum", 32'(sum_v[0]), 32'hF0);

        do_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 0, 0, ff);
        check("wrap_cout", 32'(cout_v[0]), 32'd1);
        do_op(0, 1'b0, 8'h7F, 8'h00, 1'b1, 0, 0, ff);
        check("pos_ovf", 32'({sum_v[0], ovf_v[0]}), 32'({8'h80, 1'b1}));

        do_op(0, 1'b0, 8'h12, 8'h34, 1'b1, 5, 0, ff);
        check("inject_sum", 32'(sum_v[0]), 32'h47);

        do_op(0, 1'b0, 8'h55, 8'h66, 1'b0, 0, 8, ff);
        do_op(0, 1'b0, 8'h01, 8'h01, 1'b0, 0, 0, ff);
        check("after_rst_sum", 32'(sum_v[0]), 32'h02);

        for (int c = 0; c < 8; c++)
            do_op(0, 1'b0, {7'd0, c[2]}, {7'd0, c[1]}, c[0], 0, 0, ff);

        do_op(1, 1'b0, 8'hA5, 8'h5A, 1'b1, 0, 0, ff);
        do_op(1, 1'b1, 8'h80, 8'h01, 1'b0, 0, 0, ff);
        do_op(2, 1'b0, 8'h3C, 8'hC3, 1'b0, 0, 0, ff);
        do_op(2, 1'b1, 8'h80, 8'h01, 1'b0, 0, 0, ff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/imply_serial_adder_ctrl.md
Name: imply_serial_adder_ctrl

Overview:
Bit-serial sequencer that shares one IMPLY-logic full-adder cell across all bit positions of a WIDTH-bit add/subtract operation. The controller does three things for each bit:
- drives the cell's A/B/Cin inputs;
- holds them for SETTLE cycles so the IMPLY evaluation can complete;
- captures Sum/Cout, then ripples the carry to the next bit.

It sits between a request source (start/done handshake) and the combinational IMPLY full-adder cell instantiated alongside it.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SETTLE, 2, cycles each bit's inputs are held on the cell before sampling (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
op  input  1  0 = add (a+b+cin), 1 = subtract (a-b; cin ignored)
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
cin  input  1  carry-in for add, sampled on accepted start
busy  output  1  high from the cycle after accept through the DONE cycle
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  result, registered, held until next DONE
cout  output  1  final carry-out (for subtract: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR cout
fa_a  output  1  bit driven to cell input A
fa_b  output  1  bit driven to cell input B (inverted for subtract)
fa_cin  output  1  carry driven to cell Cin
fa_sum  input  1  cell Sum output
fa_cout  input  1  cell Cout output

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0, fa_a=0, fa_b=0, fa_cin=0; bit index and settle counter = 0.
- Reset mid-operation: abandon the operation and return to IDLE with the reset values above. Do not pulse done.
- IDLE:
  - fa_* held at 0.
  - On start=1, latch a into opa and b into opb. If op=1, latch ~b into opb instead.
  - Carry register = (op ? 1 : cin).
  - Bit index i=0, settle counter=SETTLE-1, go to DRIVE.
- DRIVE:
  - fa_a=opa[i], fa_b=opb[i], fa_cin=carry, all registered and stable for exactly SETTLE cycles per bit.
  - busy=1.
  - While counter!=0, decrement the counter.
  - When counter==0:
    - shadow[i] <= fa_sum; carry <= fa_cout.
    - If i==WIDTH-1:
      - sum <= {fa_sum, shadow[WIDTH-2:0]}.
      - cout <= fa_cout.
      - ovf <= carry (carry into the MSB) XOR fa_cout.
      - Go to DONE.
    - Otherwise i <= i+1, counter <= SETTLE-1.
- DONE: done=1 and busy=1 for exactly one cycle; fa_* return to 0; go to IDLE.
- Latency: if start is accepted at cycle t, done is high in cycle t+1+WIDTH*SETTLE. With WIDTH=8, SETTLE=2 this is t+17.
- Back-to-back operation: start is not accepted in DONE. The earliest next accept is the cycle after DONE, i.e. at least one idle cycle between operations.
- start while busy: ignored. Latched operands and results are unaffected.
- Held outputs: sum, cout and ovf change only on the edge entering DONE (or on reset). Stale values persist through the next operation until its DONE.
- Result semantics: {cout,sum} equals the exact sum a+b+cin for add. For subtract it is a+~b+1 mod 2^(WIDTH+1).
- Cell wiring: fa_sum and fa_cout are sampled only at counter==0. Values at any other cycle are don't-care, which tolerates IMPLY glitching.

Test Plan:
1. WIDTH=8, SETTLE=2: add a=8'h5A, b=8'h3C, cin=0 -> sum=8'h96, cout=0, ovf=1. done pulses exactly 17 cycles after the accept cycle; busy is high for 17 cycles.
2. Subtract a=8'h10, b=8'h20 -> sum=8'hF0, cout=0 (borrow), ovf=0. Also check that fa_b shows inverted b bits (bit0: b=0 -> fa_b=1) and fa_cin=1 during bit 0.
3. Add a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then add a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
4. Assert start again at cycle 5 of an operation with different operands -> ignored; the first result and done timing are unchanged.
5. Assert rst at cycle 8 of an operation -> next cycle all outputs are 0, no done pulse; a new start afterwards completes correctly (8'h01+8'h01 -> 8'h02).
6. Reference model: all 8 single-bit combinations on bit 0 with a cell-model checker. Each fa_* input is held exactly SETTLE cycles per bit; also run SETTLE=1 and SETTLE=4, checking latency 1+WIDTH*SETTLE.
